load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit_byte_lane.sv | 60 ++++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants, funct3 encodings and FSM state type for the load/store unit.
// Imported by the interface, the byte-lane helper and the top.
package load_store_unit_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int D_BRAM_ADDR_W = 10;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5,
    ST_ERR    = 3'd6
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus data-BRAM port of the load/store unit.
// slave = the unit itself, master = core and memory side.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  // A request transfers on a rising edge where req_valid and req_ready are both
  // high; the core holds all req_* stable until then. resp_valid is a one-cycle
  // pulse with no back-pressure; resp_err and resp_rdata are qualified by it.
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [31:0]              req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic [D_BRAM_ADDR_W-1:0] mem_w_addr;
  logic [DATA_WIDTH-1:0]    mem_w_dat;
  logic                     mem_w_enb;
  logic [D_BRAM_ADDR_W-1:0] mem_r_addr;
  logic                     mem_r_enb;
  logic [DATA_WIDTH-1:0]    mem_r_dat;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_dat,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_w_addr, mem_w_dat, mem_w_enb, mem_r_addr, mem_r_enb
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_dat,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_w_addr, mem_w_dat, mem_w_enb, mem_r_addr, mem_r_enb
  );

endinterface

// File: rtl/load_store_unit_byte_lane.sv
// lsu_byte_lane: combinational load lane extraction/extension and store lane merge.
// Little-endian lanes selected by the low address bits.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_off,
  input  logic [DATA_WIDTH-1:0] i_rword,
  input  logic [DATA_WIDTH-1:0] i_old_word,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [DATA_WIDTH-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rword[7:0];
    case (i_off)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_load_data = i_rword;
    case (i_funct3)
      LSU_F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
      LSU_F3_BU: o_load_data = {24'h0, w_byte};
      LSU_F3_H:  o_load_data = {{16{w_half[15]}}, w_half};
      LSU_F3_HU: o_load_data = {16'h0, w_half};
      default:   o_load_data = i_rword;
    endcase
  end

  // Only the addressed lane comes from the store data; the rest keeps the old word.
  always_comb begin
    o_merged = i_old_word;
    case (i_funct3)
      LSU_F3_B: begin
        case (i_off)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      LSU_F3_H: begin
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port-per-direction data BRAM.
// Build option: LSU_MISALIGN_CHECK_EN turns misaligned accesses into faults.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus,
  output lsu_state_e       o_dbg_state
);

  lsu_state_e            r_state;
  lsu_state_e            w_next;
  logic [11:0]           r_addr;
  logic [2:0]            r_funct3;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_accept;
  logic [11:0]           w_ea;
  logic                  w_f3_ok;
  logic                  w_req_err;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_accept    = bus.req_valid && bus.req_ready;
  assign o_dbg_state = r_state;

  always_comb begin
    w_ea    = bus.req_addr[11:0];
    w_f3_ok = 1'b0;
    case (bus.req_funct3)
      LSU_F3_B, LSU_F3_H, LSU_F3_W: w_f3_ok = 1'b1;
      LSU_F3_BU, LSU_F3_HU:         w_f3_ok = !bus.req_we;
      default:                      w_f3_ok = 1'b0;
    endcase
    w_req_err = (|bus.req_addr[31:12]) || !w_f3_ok;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
      w_req_err = 1'b1;
    if ((bus.req_funct3[1:0] == 2'b10) && (|bus.req_addr[1:0]))
      w_req_err = 1'b1;
`else
    // Misaligned halfword/word accesses silently round down to the natural boundary.
    if (bus.req_funct3[1:0] == 2'b01) w_ea[0]   = 1'b0;
    if (bus.req_funct3[1:0] == 2'b10) w_ea[1:0] = 2'b00;
`endif
  end

  lsu_byte_lane u_lane (
    .i_funct3    (r_funct3),
    .i_off       (r_addr[1:0]),
    .i_rword     (bus.mem_r_dat),
    .i_old_word  (r_data),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                    w_next = ST_ERR;
          else if (!bus.req_we)             w_next = ST_LOAD;
          else if (bus.req_funct3 == LSU_F3_W) w_next = ST_WRITE;
          else                              w_next = ST_RMW_RD;
        end
      end
      ST_LOAD, ST_WRITE: w_next = ST_RESP;
      ST_RMW_RD:         w_next = ST_RMW_WR;
      ST_RMW_WR:         w_next = ST_RESP;
      ST_RESP, ST_ERR:   w_next = ST_IDLE;
      default:           w_next = ST_IDLE;
    endcase
  end

  // r_data holds the extended load result, or the raw old word during a sub-word store.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_data   <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= w_ea;
        r_funct3 <= bus.req_funct3;
        r_we     <= bus.req_we;
        r_wdata  <= bus.req_wdata;
      end
      if (r_state == ST_LOAD)   r_data <= w_load_data;
      if (r_state == ST_RMW_RD) r_data <= bus.mem_r_dat;
    end
  end

  // All outputs are gated by rst so nothing escapes during the reset cycle itself.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_w_addr = '0;
    bus.mem_w_dat  = '0;
    bus.mem_w_enb  = 1'b0;
    bus.mem_r_addr = '0;
    bus.mem_r_enb  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: bus.req_ready = 1'b1;
        ST_LOAD, ST_RMW_RD: begin
          bus.mem_r_enb  = 1'b1;
          bus.mem_r_addr = r_addr[11:2];
        end
        ST_WRITE: begin
          bus.mem_w_enb  = 1'b1;
          bus.mem_w_addr = r_addr[11:2];
          bus.mem_w_dat  = r_wdata;
        end
        ST_RMW_WR: begin
          bus.mem_w_enb  = 1'b1;
          bus.mem_w_addr = r_addr[11:2];
          bus.mem_w_dat  = w_merged;
        end
        ST_RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = r_we ? '0 : r_data;
        end
        ST_ERR: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: BRAM model, reference memory model and response scoreboard.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  lsu_state_e dbg_state;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model with a preload port
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pl_en = 1'b0;
  logic        mem_clr = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;

  always_comb bus.mem_r_dat = bus.mem_r_enb ? mem[bus.mem_r_addr] : 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_dat;
    end else if (bus.mem_w_enb) begin
      mem[bus.mem_w_addr] <= bus.mem_w_dat;
    end
  end

  // Scoreboard
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_rd = 0, n_wr = 0, n_resp = 0;
  int          last_r_cyc = 0, last_w_cyc = 0;
  logic [9:0]  last_w_addr = '0;
  logic [31:0] last_w_dat = '0;

  always @(negedge clk) begin
    if (bus.mem_r_enb === 1'b1) begin
      n_rd++;
      last_r_cyc = cyc;
    end
    if (bus.mem_w_enb === 1'b1) begin
      n_wr++;
      last_w_cyc  = cyc;
      last_w_addr = bus.mem_w_addr;
      last_w_dat  = bus.mem_w_dat;
    end
    if (bus.mem_r_enb === 1'b1 || bus.mem_w_enb === 1'b1) begin
      total++;
      if (bus.mem_r_enb === 1'b1 && bus.mem_w_enb === 1'b1) begin
        bad++;
        $display("FAIL enb_overlap: r_enb and w_enb both 1 at cycle %0d", cyc);
      end
    end
    if (bus.resp_valid === 1'b1) begin
      n_resp++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got err=%b rdata=%h, expected no response", bus.resp_err, bus.resp_rdata);
      end else begin
        logic [32:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({bus.resp_err, bus.resp_rdata} !== e) begin
          bad++;
          $display("FAIL resp_data: got err=%b rdata=%h, expected err=%b rdata=%h", bus.resp_err, bus.resp_rdata, e[32], e[31:0]);
        end
        total++;
        if (cyc !== ec) begin
          bad++;
          $display("FAIL resp_latency: got cycle %0d, expected cycle %0d", cyc, ec);
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = idx[9:0];
    pl_dat  = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [32:0] e, input int lat,
                      input logic push, output int acc);
    int waited;
    waited = 0;
    acc    = -1;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=%b, expected 1 within 50 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
    end else begin
      acc = cyc;
      if (push) begin
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + lat);
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [32:0] e, output int lat);
    logic        err, f3_ok;
    logic [11:0] ea;
    logic [31:0] w, sh, mask;
    int          sa;
    ea = addr[11:0];
    if (we) f3_ok = f3 inside {3'd0, 3'd1, 3'd2};
    else    f3_ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    err = (addr[31:12] != 20'h0) || !f3_ok;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00)) err = 1'b1;
`else
    if (f3[1:0] == 2'b01) ea[0] = 1'b0;
    if (f3[1:0] == 2'b10) ea[1:0] = 2'b00;
`endif
    sa = 8 * int'(ea[1:0]);
    w  = ref_mem[ea[11:2]];
    e  = 33'h0;
    if (err) begin
      e   = {1'b1, 32'h0};
      lat = 1;
    end else if (!we) begin
      sh  = w >> sa;
      lat = 2;
      case (f3)
        3'd0:    e = {1'b0, {24{sh[7]}}, sh[7:0]};
        3'd4:    e = {1'b0, 24'h0, sh[7:0]};
        3'd1:    e = {1'b0, {16{sh[15]}}, sh[15:0]};
        3'd5:    e = {1'b0, 16'h0, sh[15:0]};
        default: e = {1'b0, w};
      endcase
    end else begin
      if (f3 == 3'd0)      mask = 32'hFF << sa;
      else if (f3 == 3'd1) mask = 32'hFFFF << sa;
      else                 mask = 32'hFFFF_FFFF;
      lat = (f3 == 3'd2) ? 2 : 3;
      ref_mem[ea[11:2]] = (w & ~mask) | ((wdata << sa) & mask);
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output int acc);
    logic [32:0] e;
    ref_access(we, f3, addr, wdata, e, lat);
    send(we, f3, addr, wdata, e, lat, 1'b1, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL resp_timeout: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    mem_clr        = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = LSU_F3_W;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_w_addr, bus.mem_w_dat,
         bus.mem_w_enb, bus.mem_r_addr, bus.mem_r_enb} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b rv=%b err=%b r_enb=%b w_enb=%b, expected all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_r_enb, bus.mem_w_enb);
    end
    bus.req_valid = 1'b0;
    mem_clr       = 1'b0;
    rst           = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_release: got ready=%b state=%0d, expected ready=1 state=0", bus.req_ready, dbg_state);
    end
  endtask

  task automatic test_load();
    int acc;
    preload(5, 32'h8765_43A1);
    send(1'b0, LSU_F3_B,  32'h17, 32'h0, {1'b0, 32'hFFFF_FF87}, 2, 1'b1, acc);
    send(1'b0, LSU_F3_B,  32'h16, 32'h0, {1'b0, 32'h0000_0065}, 2, 1'b1, acc);
    send(1'b0, LSU_F3_HU, 32'h14, 32'h0, {1'b0, 32'h0000_43A1}, 2, 1'b1, acc);
    send(1'b0, LSU_F3_BU, 32'h14, 32'h0, {1'b0, 32'h0000_00A1}, 2, 1'b1, acc);
    send(1'b0, LSU_F3_H,  32'h16, 32'h0, {1'b0, 32'hFFFF_8765}, 2, 1'b1, acc);
    send(1'b0, LSU_F3_W,  32'h14, 32'h0, {1'b0, 32'h8765_43A1}, 2, 1'b1, acc);
    drain();
  endtask

  task automatic test_store_rmw();
    int acc, rd0, wr0;
    preload(5, 32'h1122_3344);
    rd0 = n_rd;
    wr0 = n_wr;
    send(1'b1, LSU_F3_B, 32'h15, 32'h0000_00AB, 33'h0, 3, 1'b1, acc);
    drain();
    total++;
    if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1 || last_w_cyc !== last_r_cyc + 1) begin
      bad++;
      $display("FAIL sb_sequence: got rd=%0d wr=%0d r_cyc=%0d w_cyc=%0d, expected rd=1 wr=1 w one after r",
               n_rd - rd0, n_wr - wr0, last_r_cyc, last_w_cyc);
    end
    total++;
    if (last_w_dat !== 32'h1122_AB44 || last_w_addr !== 10'd5) begin
      bad++;
      $display("FAIL sb_merge: got addr=%h dat=%h, expected addr=005 dat=1122ab44", last_w_addr, last_w_dat);
    end
    send(1'b1, LSU_F3_H, 32'h16, 32'h1234_BEEF, 33'h0, 3, 1'b1, acc);
    drain();
    total++;
    if (last_w_dat !== 32'hBEEF_AB44) begin
      bad++;
      $display("FAIL sh_merge: got dat=%h, expected beefab44", last_w_dat);
    end
    send(1'b0, LSU_F3_W, 32'h14, 32'h0, {1'b0, 32'hBEEF_AB44}, 2, 1'b1, acc);
    drain();
  endtask

  task automatic test_sw_err();
    int acc, rd0, wr0;
    rd0 = n_rd;
    send(1'b1, LSU_F3_W, 32'hFFC, 32'hDEAD_BEEF, 33'h0, 2, 1'b1, acc);
    drain();
    ref_mem[1023] = 32'hDEAD_BEEF;
    total++;
    if (last_w_addr !== 10'h3FF || last_w_dat !== 32'hDEAD_BEEF || n_rd !== rd0) begin
      bad++;
      $display("FAIL sw_write: got addr=%h dat=%h reads=%0d, expected addr=3ff dat=deadbeef reads=0",
               last_w_addr, last_w_dat, n_rd - rd0);
    end
    rd0 = n_rd;
    wr0 = n_wr;
    send(1'b0, LSU_F3_W, 32'h1000, 32'h0, {1'b1, 32'h0}, 1, 1'b1, acc);
    send(1'b0, 3'b011, 32'h10, 32'h0, {1'b1, 32'h0}, 1, 1'b1, acc);
    send(1'b1, LSU_F3_BU, 32'h10, 32'h55, {1'b1, 32'h0}, 1, 1'b1, acc);
    drain();
    total++;
    if (n_rd !== rd0 || n_wr !== wr0) begin
      bad++;
      $display("FAIL err_no_access: got reads=%0d writes=%0d, expected 0 and 0", n_rd - rd0, n_wr - wr0);
    end
    send(1'b0, LSU_F3_W, 32'hFFC, 32'h0, {1'b0, 32'hDEAD_BEEF}, 2, 1'b1, acc);
    drain();
  endtask

  task automatic test_misalign();
    int acc;
    preload(0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_CHECK_EN
    send(1'b0, LSU_F3_W, 32'h02, 32'h0, {1'b1, 32'h0}, 1, 1'b1, acc);
    send(1'b0, LSU_F3_H, 32'h01, 32'h0, {1'b1, 32'h0}, 1, 1'b1, acc);
    send(1'b1, LSU_F3_W, 32'h03, 32'h1234_5678, {1'b1, 32'h0}, 1, 1'b1, acc);
    send(1'b0, LSU_F3_W, 32'h00, 32'h0, {1'b0, 32'hCAFE_F00D}, 2, 1'b1, acc);
`else
    send(1'b0, LSU_F3_W, 32'h02, 32'h0, {1'b0, 32'hCAFE_F00D}, 2, 1'b1, acc);
    send(1'b0, LSU_F3_H, 32'h01, 32'h0, {1'b0, 32'hFFFF_F00D}, 2, 1'b1, acc);
    send(1'b1, LSU_F3_W, 32'h03, 32'h1234_5678, 33'h0, 2, 1'b1, acc);
    send(1'b0, LSU_F3_W, 32'h00, 32'h0, {1'b0, 32'h1234_5678}, 2, 1'b1, acc);
    ref_mem[0] = 32'h1234_5678;
`endif
    drain();
  endtask

  task automatic test_random();
    int lat, acc;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) preload(i, $urandom());
    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = addr | 32'h0001_0000;
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom(), lat, acc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int l0, l1, l2, l3, a0, a1, a2, a3;
    run(1'b0, LSU_F3_W,  32'h24, 32'h0,  l0, a0);
    run(1'b1, LSU_F3_B,  32'h21, 32'h5A, l1, a1);
    run(1'b0, LSU_F3_BU, 32'h21, 32'h0,  l2, a2);
    run(1'b0, LSU_F3_W,  32'h2000, 32'h0, l3, a3);
    drain();
    total++;
    if (a1 - a0 !== l0 + 1 || a2 - a1 !== l1 + 1 || a3 - a2 !== l2 + 1) begin
      bad++;
      $display("FAIL b2b_accept: got gaps %0d %0d %0d, expected %0d %0d %0d",
               a1 - a0, a2 - a1, a3 - a2, l0 + 1, l1 + 1, l2 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int acc, wr0, resp0;
    preload(5, 32'h1122_3344);
    wr0   = n_wr;
    resp0 = n_resp;
    send(1'b1, LSU_F3_H, 32'h14, 32'h0000_9999, 33'h0, 3, 1'b0, acc);
    total++;
    if (dbg_state !== ST_RMW_RD) begin
      bad++;
      $display("FAIL mid_state: got state=%0d, expected %0d", dbg_state, ST_RMW_RD);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_r_enb !== 1'b0 || bus.mem_w_enb !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_outputs: got r_enb=%b w_enb=%b ready=%b, expected 0 0 0",
               bus.mem_r_enb, bus.mem_w_enb, bus.req_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_ready: got ready=%b, expected 1", bus.req_ready);
    end
    repeat (6) @(negedge clk);
    total++;
    if (n_wr !== wr0 || n_resp !== resp0 || mem[5] !== 32'h1122_3344) begin
      bad++;
      $display("FAIL mid_abort: got writes=%0d resps=%0d word5=%h, expected 0 0 11223344",
               n_wr - wr0, n_resp - resp0, mem[5]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_load();
    test_store_rmw();
    test_sw_err();
    test_misalign();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
